// File: rtl/axi_ram_wr_sched_if.sv
// Purpose : AXI4 write-channel bundle (AW/W/B) between the write scheduler and the RAM slave.
// Latency : none, wires only.
// Backpressure: carried by awready/wready (slave to master) and bready (master to slave).
// Ports   : master drives aw*, w*, bready; slave drives awready, wready, bresp, bvalid.
interface axi_ram_wr_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid,
        input  bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_ram_wr_sched.sv
// Purpose : splits a (byte address, word count) job into 4 KB-safe INCR write bursts to an AXI4 RAM.
// Latency : AW one cycle after start or previous B; W beats pass straight through; done one cycle after last B.
// Backpressure: one burst outstanding; producer stalls and wready stalls pass through combinationally.
// Ports   : clk/rst; i_start/i_cfg_addr/i_cfg_words job request; o_busy/o_done/o_err status;
//           i_s_data/i_s_valid/o_s_ready producer stream; m_axi AXI4 write master (AW/W/B).
module axi_ram_wr_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int BURST_MAX  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_cfg_addr,
    input  logic [CNT_WIDTH-1:0]  i_cfg_words,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    axi_ram_wr_sched_if.master    m_axi
);
    localparam int ALIGN = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remaining;
    logic [7:0]            r_len;       // current burst length minus one, held until RESP completes
    logic [7:0]            r_beat;
    logic                  r_awvalid;
    logic                  r_bready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_start_addr;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [CNT_WIDTH-1:0]  w_next_rem;
    logic [8:0]            w_beats;
    logic                  w_in_data;
    logic                  w_wlast;
    logic                  w_w_hs;

    // Burst length minus one: smallest of words left, BURST_MAX and words up to the next 4 KB line.
    // Because the wrap point of the address space is itself 4 KB aligned, this also stops wrap straddles.
    function automatic logic [7:0] f_len(input logic [11:0] a_lo, input logic [CNT_WIDTH-1:0] rem);
        logic [31:0] room;
        logic [31:0] n;
        room = (32'd4096 - {20'd0, a_lo}) >> ALIGN;
        n    = 32'(BURST_MAX);
        if (room < n)
            n = room;
        if (32'(rem) < n)
            n = 32'(rem);
        return 8'(n - 32'd1);
    endfunction

    assign w_start_addr = i_cfg_addr & ALIGN_MASK;
    assign w_beats      = {1'b0, r_len} + 9'd1;
    assign w_next_addr  = r_addr + (ADDR_WIDTH'(w_beats) << ALIGN);
    assign w_next_rem   = r_remaining - CNT_WIDTH'(w_beats);
    assign w_in_data    = (r_state == ST_DATA);
    assign w_wlast      = w_in_data && (r_beat == r_len);
    assign w_w_hs       = w_in_data && i_s_valid && m_axi.wready;

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_s_ready     = w_in_data && m_axi.wready;

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awlen   = r_len;
    assign m_axi.awsize  = 3'(ALIGN);
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = i_s_data;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = w_wlast;
    assign m_axi.wvalid  = w_in_data && i_s_valid;
    assign m_axi.bready  = r_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_beat      <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_cfg_words != '0) begin
                            r_addr      <= w_start_addr;
                            r_remaining <= i_cfg_words;
                            r_len       <= f_len(w_start_addr[11:0], i_cfg_words);
                            r_err       <= 1'b0;
                            r_busy      <= 1'b1;
                            r_awvalid   <= 1'b1;
                            r_state     <= ST_ADDR;
                        end else begin
                            // empty job: acknowledge without touching the bus
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (r_awvalid && m_axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (w_wlast) begin
                            r_bready <= 1'b1;
                            r_state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_err       <= r_err | (m_axi.bresp != 2'b00);
                        r_addr      <= w_next_addr;
                        r_remaining <= w_next_rem;
                        if (w_next_rem == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_len     <= f_len(w_next_addr[11:0], w_next_rem);
                            r_awvalid <= 1'b1;
                            r_state   <= ST_ADDR;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ram_wr_sched.sv
// Purpose : directed bench for axi_ram_wr_sched with a behavioural AXI RAM slave and word producer.
// Latency : n/a (bench).
// Backpressure: slave readies, producer valid and B delay are random when stress is set, else always ready.
module tb_axi_ram_wr_sched;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_cfg_addr;
    logic [CW-1:0] i_cfg_words;
    logic          o_busy, o_done, o_err;
    logic [DW-1:0] i_s_data;
    logic          i_s_valid, o_s_ready;

    always #5 clk = ~clk;

    axi_ram_wr_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

    axi_ram_wr_sched #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(16), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_start(i_start), .i_cfg_addr(i_cfg_addr), .i_cfg_words(i_cfg_words),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .m_axi(axi)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // behavioural slave / producer state
    logic [31:0]   mem [16384];
    bit            stress = 1'b0;
    int unsigned   prod_seq = 0;
    logic [AW-1:0] cur_addr;
    logic [7:0]    cur_len;
    logic [7:0]    beat;
    bit            w_open, aw_open, b_pending;
    logic [1:0]    cur_bresp;
    bit            prev_aw_stall;
    logic [AW-1:0] prev_awaddr;
    logic [7:0]    prev_awlen;
    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_len_q[$];
    logic [1:0]    resp_q[$];
    logic [AW-1:0] ea;
    logic [7:0]    el;
    int            done_cnt = 0;
    int            aw_vld_cycles = 0;
    int            job_beats = 0;

    task automatic push_aw(input logic [AW-1:0] a, input logic [7:0] l);
        exp_addr_q.push_back(a);
        exp_len_q.push_back(l);
    endtask

    // drive on the falling edge, observe 4 ns later (1 ns before the rising edge)
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        i_s_valid = 1'b0; i_s_data = '0;
        w_open = 0; aw_open = 0; b_pending = 0; prev_aw_stall = 0;
        cur_addr = '0; cur_len = '0; beat = '0; cur_bresp = 2'b00;
        forever begin
            @(negedge clk);
            axi.awready = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
            axi.wready  = stress ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_s_valid   = stress ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_s_data    = prod_seq;
            if (!b_pending) begin
                axi.bvalid = 1'b0;
                axi.bresp  = 2'b00;
            end else if (!axi.bvalid && (!stress || $urandom_range(0, 2) == 0)) begin
                axi.bvalid = 1'b1;
                axi.bresp  = cur_bresp;
            end
            #4;
            if (rst) begin
                w_open = 0; aw_open = 0; b_pending = 0; prev_aw_stall = 0;
            end else begin
                if (o_done) done_cnt++;
                if (axi.awvalid) aw_vld_cycles++;
                if (axi.awvalid && prev_aw_stall) begin
                    chk("aw_stable_addr", axi.awaddr, prev_awaddr);
                    chk("aw_stable_len", axi.awlen, prev_awlen);
                end
                prev_aw_stall = axi.awvalid && !axi.awready;
                prev_awaddr   = axi.awaddr;
                prev_awlen    = axi.awlen;
                if (axi.awvalid && axi.awready) begin
                    chk("aw_one_outstanding", aw_open, 0);
                    chk("awsize", axi.awsize, 2);
                    chk("awburst", axi.awburst, 1);
                    chk("aw_queue_nonempty", exp_addr_q.size() != 0, 1);
                    if (exp_addr_q.size() != 0) begin
                        ea = exp_addr_q.pop_front();
                        el = exp_len_q.pop_front();
                        chk("awaddr", axi.awaddr, ea);
                        chk("awlen", axi.awlen, el);
                    end
                    cur_addr = axi.awaddr; cur_len = axi.awlen; beat = '0;
                    aw_open = 1; w_open = 1;
                end
                if (axi.wvalid && axi.wready) begin
                    chk("w_after_aw", w_open, 1);
                    chk("wlast", axi.wlast, beat == cur_len);
                    chk("wstrb", axi.wstrb, 4'hF);
                    mem[((int'(cur_addr) >> 2) + int'(beat)) % 16384] = axi.wdata;
                    beat = beat + 8'd1;
                    job_beats++;
                    if (axi.wlast) begin
                        w_open = 0;
                        b_pending = 1;
                        cur_bresp = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
                    end
                end
                if (i_s_valid && o_s_ready) prod_seq++;
                if (axi.bvalid && axi.bready) begin
                    aw_open = 0;
                    b_pending = 0;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_awvalid"}, axi.awvalid, 0);
        chk({tag, "_bready"}, axi.bready, 0);
        chk({tag, "_wvalid"}, axi.wvalid, 0);
        chk({tag, "_s_ready"}, o_s_ready, 0);
        chk({tag, "_wlast"}, axi.wlast, 0);
        chk({tag, "_awaddr"}, axi.awaddr, 0);
        chk({tag, "_awlen"}, axi.awlen, 0);
    endtask

    task automatic run_job(input logic [AW-1:0] addr, input int words, input string tag);
        int unsigned base;
        int bad;
        int d0;
        bit got_done;
        @(negedge clk);
        i_start = 1'b1; i_cfg_addr = addr; i_cfg_words = CW'(words);
        base = prod_seq;
        d0 = done_cnt;
        job_beats = 0;
        @(negedge clk);
        i_start = 1'b0;
        got_done = 0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk);
            if (done_cnt != d0) got_done = 1;
        end
        chk({tag, "_done_seen"}, got_done, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_beats"}, job_beats, words);
        chk({tag, "_aw_all_issued"}, exp_addr_q.size(), 0);
        chk({tag, "_busy_after"}, o_busy, 0);
        bad = 0;
        for (int i = 0; i < words; i++)
            if (mem[((int'(addr) >> 2) + i) % 16384] !== base + i) bad++;
        chk({tag, "_data"}, bad, 0);
    endtask

    initial begin
        int d0;
        int a0;
        bit reached;
        rst = 1'b1; i_start = 1'b0; i_cfg_addr = '0; i_cfg_words = '0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // single burst
        push_aw(16'h0100, 8'd9);
        run_job(16'h0100, 10, "single");

        // BURST_MAX split
        push_aw(16'h0000, 8'd15); push_aw(16'h0040, 8'd15); push_aw(16'h0080, 8'd7);
        run_job(16'h0000, 40, "split16");

        // 4 KB split
        push_aw(16'h0FF8, 8'd1); push_aw(16'h1000, 8'd3);
        run_job(16'h0FF8, 6, "split4k");

        // top-of-memory wrap
        push_aw(16'hFFF0, 8'd3); push_aw(16'h0000, 8'd3);
        run_job(16'hFFF0, 8, "wrap");

        // stalls everywhere, SLVERR on the middle burst
        stress = 1'b1;
        push_aw(16'h0200, 8'd15); push_aw(16'h0240, 8'd15); push_aw(16'h0280, 8'd7);
        resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
        run_job(16'h0200, 40, "stress");
        chk("stress_err_sticky", o_err, 1);
        stress = 1'b0;

        // next accepted start clears err
        push_aw(16'h0400, 8'd3);
        run_job(16'h0400, 4, "errclr");
        chk("errclr_err", o_err, 0);

        // reset in the middle of a data phase
        push_aw(16'h0800, 8'd15);
        @(negedge clk);
        i_start = 1'b1; i_cfg_addr = 16'h0800; i_cfg_words = 16'd20;
        job_beats = 0;
        @(negedge clk);
        i_start = 1'b0;
        reached = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            @(negedge clk);
            if (job_beats >= 3) reached = 1;
        end
        chk("rst_reached_data", reached, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        exp_addr_q.delete(); exp_len_q.delete(); resp_q.delete();
        push_aw(16'h0900, 8'd4);
        run_job(16'h0900, 5, "post_rst");

        // zero-length job
        d0 = done_cnt;
        a0 = aw_vld_cycles;
        @(negedge clk);
        i_start = 1'b1; i_cfg_addr = 16'h0300; i_cfg_words = '0;
        @(negedge clk);
        i_start = 1'b0;
        #1;
        chk("zero_done_pulse", o_done, 1);
        chk("zero_busy", o_busy, 0);
        repeat (5) @(negedge clk);
        chk("zero_done_once", done_cnt - d0, 1);
        chk("zero_no_awvalid", aw_vld_cycles - a0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
